othello_dir_scanner: RTL

// Datapath responder to the new-move controller: walks the board RAM from a move origin along one

---
 rtl/othello_dir_scanner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/othello_dir_scanner.sv
// Othello direction scanner: walks the board RAM from a move origin along one step direction,
// validates the flanked opponent run and optionally overwrites it with the mover's colour.
module othello_dir_scanner #(
  parameter int ADDR_W      = 7,
  parameter int BOARD_CELLS = 100,
  parameter int MAX_RUN     = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_i,
  input  logic [ADDR_W-1:0] origin_i,
  input  logic [4:0]        step_i,
  input  logic [1:0]        player_i,
  input  logic              flip_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [1:0]        mem_rdata_i,
  output logic              mem_we_o,
  output logic [1:0]        mem_wdata_o,
  output logic              busy_o,
  output logic              s_done_o,
  output logic              dir_status_o,
  output logic [2:0]        flip_count_o
);

  typedef enum logic [2:0] {IDLE, RD, EV, FL, DONE} state_t;

  localparam logic signed [ADDR_W:0] CELLS_S = (ADDR_W + 1)'(BOARD_CELLS);
  localparam logic [2:0]             RUN_MAX = 3'(MAX_RUN);

  state_t                   state, state_next;
  logic [ADDR_W-1:0]        origin_q, origin_next;
  logic [4:0]               step_q, step_next;
  logic [1:0]               player_q, player_next;
  logic                     flip_q, flip_next;
  logic signed [ADDR_W:0]   cur, cur_next;
  logic [2:0]               count, count_next;
  logic [2:0]               left, left_next;
  logic                     status_next;
  logic [2:0]               fcount_next;

  logic signed [ADDR_W:0]   step_ext, first_cell, ld_first_cell;
  logic                     oob;
  logic [1:0]               opponent;

  assign step_ext      = {{(ADDR_W - 4){step_q[4]}}, step_q};
  assign first_cell    = $signed({1'b0, origin_q}) + step_ext;
  assign ld_first_cell = $signed({1'b0, origin_i}) + $signed({{(ADDR_W - 4){step_i[4]}}, step_i});
  // Negative or past-the-end addresses are treated as border; no wrap-around.
  assign oob           = cur[ADDR_W] || (cur >= CELLS_S);
  assign opponent      = ~player_q;

  assign busy_o      = (state != IDLE);
  assign s_done_o    = (state == DONE);
  assign mem_wdata_o = player_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      origin_q     <= '0;
      step_q       <= '0;
      player_q     <= '0;
      flip_q       <= 1'b0;
      cur          <= '0;
      count        <= '0;
      left         <= '0;
      dir_status_o <= 1'b0;
      flip_count_o <= '0;
    end else begin
      state        <= state_next;
      origin_q     <= origin_next;
      step_q       <= step_next;
      player_q     <= player_next;
      flip_q       <= flip_next;
      cur          <= cur_next;
      count        <= count_next;
      left         <= left_next;
      dir_status_o <= status_next;
      flip_count_o <= fcount_next;
    end
  end

  always_comb begin
    state_next  = state;
    origin_next = origin_q;
    step_next   = step_q;
    player_next = player_q;
    flip_next   = flip_q;
    cur_next    = cur;
    count_next  = count;
    left_next   = left;
    status_next = dir_status_o;
    fcount_next = flip_count_o;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;

    case (state)
      IDLE: begin
        if (ld_i) begin
          origin_next = origin_i;
          step_next   = step_i;
          player_next = player_i;
          flip_next   = flip_i;
        end
        if (start_i) begin
          // A same-cycle load must steer the very first address.
          cur_next    = ld_i ? ld_first_cell : first_cell;
          count_next  = '0;
          status_next = 1'b0;
          fcount_next = '0;
          state_next  = RD;
        end
      end

      RD: begin
        if (!oob) mem_addr_o = cur[ADDR_W-1:0];
        state_next = EV;
      end

      EV: begin
        if (!oob && mem_rdata_i == opponent) begin
          if (count == RUN_MAX) begin
            state_next = DONE;
          end else begin
            count_next = count + 3'd1;
            cur_next   = cur + step_ext;
            state_next = RD;
          end
        end else if (!oob && mem_rdata_i == player_q && count != 3'd0) begin
          if (flip_q) begin
            cur_next   = first_cell;
            left_next  = count;
            state_next = FL;
          end else begin
            status_next = 1'b1;
            fcount_next = count;
            state_next  = DONE;
          end
        end else begin
          state_next = DONE;
        end
      end

      FL: begin
        mem_we_o   = 1'b1;
        mem_addr_o = cur[ADDR_W-1:0];
        cur_next   = cur + step_ext;
        left_next  = left - 3'd1;
        if (left == 3'd1) begin
          status_next = 1'b1;
          fcount_next = count;
          state_next  = DONE;
        end
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

endmodule
